pipelined_memops: RTL and testbench

PIPELINED_MEMOPS -- requirements
Module: pipelined_memops

---
 rtl/pipelined_memops_if.sv | 29 ++
 rtl/pipelined_memops.sv | 225 ++++++++++++++++++++++
 tb/tb_pipelined_memops.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_memops_if.sv
// Pipelined Wishbone bus between the memory-op engine (master) and memory (slave).
interface pipelined_memops_if #(
    parameter int AW = 30
);
    logic          o_wb_cyc_gbl;
    logic          o_wb_cyc_lcl;
    logic          o_wb_stb_gbl;
    logic          o_wb_stb_lcl;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_ack;
    logic          i_wb_stall;
    logic          i_wb_err;
    logic [31:0]   i_wb_data;

    modport master (
        output o_wb_cyc_gbl, o_wb_cyc_lcl, o_wb_stb_gbl, o_wb_stb_lcl, o_wb_we,
               o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
    );

    modport slave (
        input  o_wb_cyc_gbl, o_wb_cyc_lcl, o_wb_stb_gbl, o_wb_stb_lcl, o_wb_we,
               o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
    );
endinterface

// File: rtl/pipelined_memops.sv
// Pipelined load/store unit: issues CPU memory ops as pipelined Wishbone
// requests, tracks outstanding reads in a return FIFO and realigns results.
module pipelined_memops #(
    parameter int ADDRESS_WIDTH  = 30,
    parameter int LGDEPTH        = 3,
    parameter int IMPLEMENT_LOCK = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stb,
    input  logic        i_lock,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_oreg,
    output logic        o_busy,
    output logic        o_pipe_stalled,
    output logic        o_valid,
    output logic        o_err,
    output logic [4:0]  o_wreg,
    output logic [31:0] o_result,
    pipelined_memops_if.master wb
);
    localparam int AW    = ADDRESS_WIDTH;
    localparam int DEPTH = 1 << LGDEPTH;
    localparam int CW    = LGDEPTH + 1;

    // What a returning ack needs to know to realign its data
    typedef struct packed {
        logic [4:0] oreg;
        logic [1:0] size;
        logic [1:0] off;
    } ret_t;

    logic               cyc_gbl_q, cyc_gbl_d, cyc_lcl_q, cyc_lcl_d;
    logic               stb_gbl_q, stb_gbl_d, stb_lcl_q, stb_lcl_d;
    logic               lock_q, lock_d, valid_q, valid_d, err_q, err_d;
    logic [CW-1:0]      npend_q, npend_d;
    logic [LGDEPTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d, result_q, result_d;
    logic [3:0]         sel_q, sel_d;
    logic [4:0]         wreg_q, wreg_d;
    ret_t               pend_q, pend_d;
    ret_t               fifo_q [DEPTH];
    ret_t               fifo_d [DEPTH];

    logic        is_local, misaligned, cyc, stb, inflight, full;
    logic        accept, acc_bus, acc_mis, issue, ack, berr, lock_hold;
    logic [CW:0] in_use;
    logic [3:0]  req_sel;
    logic [31:0] req_data, lane;
    ret_t        head;

    // Request decode, stall decision and read-lane extraction
    always_comb begin
        is_local = (i_addr[31:24] == 8'hff);
        cyc      = cyc_gbl_q | cyc_lcl_q;
        stb      = stb_gbl_q | stb_lcl_q;
        inflight = (npend_q != '0) || stb;
        // a request still sitting on STB will occupy a FIFO slot too
        in_use   = {1'b0, npend_q} + (CW+1)'(stb);
        full     = in_use >= (CW+1)'(DEPTH);
        case (i_op[2:1])
            2'b01: begin
                misaligned = i_addr[0];
                req_sel    = i_addr[1] ? 4'b0011 : 4'b1100;
                req_data   = {2{i_data[15:0]}};
            end
            2'b10: begin
                misaligned = 1'b0;
                req_sel    = 4'b1000 >> i_addr[1:0];
                req_data   = {4{i_data[7:0]}};
            end
            default: begin
                misaligned = (i_addr[1:0] != 2'b00);
                req_sel    = 4'b1111;
                req_data   = i_data;
            end
        endcase
        o_pipe_stalled = (stb && wb.i_wb_stall) || full
                       || (inflight && ((i_op[0] != we_q) || (is_local != cyc_lcl_q)))
                       || (misaligned && cyc);
        accept    = i_stb && !o_pipe_stalled;
        acc_bus   = accept && !misaligned;
        acc_mis   = accept && misaligned;
        issue     = stb && !wb.i_wb_stall;
        ack       = cyc && wb.i_wb_ack && (npend_q != '0);
        berr      = cyc && wb.i_wb_err;
        lock_hold = (IMPLEMENT_LOCK != 0) && lock_q && i_lock;
        head      = fifo_q[rptr_q];
        // big-endian lanes: byte offset 0 lives in bits [31:24]
        case (head.size)
            2'b10:   lane = {24'h0, 8'(wb.i_wb_data >> {~head.off, 3'b000})};
            2'b01:   lane = {16'h0, 16'(wb.i_wb_data >> {~head.off[1], 4'b0000})};
            default: lane = wb.i_wb_data;
        endcase
    end

    // Next-state for bus control, pending count, return FIFO and result
    always_comb begin
        cyc_gbl_d = cyc_gbl_q;
        cyc_lcl_d = cyc_lcl_q;
        stb_gbl_d = stb_gbl_q;
        stb_lcl_d = stb_lcl_q;
        npend_d   = npend_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        fifo_d    = fifo_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        pend_d    = pend_q;
        wreg_d    = wreg_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        lock_d    = 1'b0;
        if (berr) begin
            // abandon everything in flight; stray acks after this are ignored
            cyc_gbl_d = 1'b0;
            cyc_lcl_d = 1'b0;
            stb_gbl_d = 1'b0;
            stb_lcl_d = 1'b0;
            npend_d   = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            err_d     = 1'b1;
        end else begin
            case ({issue, ack})
                2'b10:   npend_d = npend_q + 1'b1;
                2'b01:   npend_d = npend_q - 1'b1;
                default: npend_d = npend_q;
            endcase
            if (issue) begin
                fifo_d[wptr_q] = pend_q;
                wptr_d         = wptr_q + 1'b1;
                stb_gbl_d      = 1'b0;
                stb_lcl_d      = 1'b0;
            end
            if (ack) begin
                rptr_d = rptr_q + 1'b1;
                if (!we_q) begin
                    valid_d  = 1'b1;
                    wreg_d   = head.oreg;
                    result_d = lane;
                end
            end
            if (acc_bus) begin
                cyc_gbl_d = !is_local;
                cyc_lcl_d = is_local;
                stb_gbl_d = !is_local;
                stb_lcl_d = is_local;
                we_d      = i_op[0];
                addr_d    = i_addr[AW+1:2];
                wdata_d   = req_data;
                sel_d     = req_sel;
                pend_d    = '{oreg: i_oreg, size: i_op[2:1], off: i_addr[1:0]};
            end else if ((npend_d == '0) && !(stb_gbl_d || stb_lcl_d) && !lock_hold) begin
                cyc_gbl_d = 1'b0;
                cyc_lcl_d = 1'b0;
            end
            if (acc_mis) begin
                err_d  = 1'b1;
                wreg_d = i_oreg;
            end
            lock_d = (IMPLEMENT_LOCK != 0) && i_lock && (cyc_gbl_d || cyc_lcl_d);
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cyc_gbl_q <= 1'b0;
            cyc_lcl_q <= 1'b0;
            stb_gbl_q <= 1'b0;
            stb_lcl_q <= 1'b0;
            lock_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            npend_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            cyc_gbl_q <= cyc_gbl_d;
            cyc_lcl_q <= cyc_lcl_d;
            stb_gbl_q <= stb_gbl_d;
            stb_lcl_q <= stb_lcl_d;
            lock_q    <= lock_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            npend_q   <= npend_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    // Datapath registers and FIFO storage need no reset
    always_ff @(posedge i_clk) begin
        we_q     <= we_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        sel_q    <= sel_d;
        pend_q   <= pend_d;
        wreg_q   <= wreg_d;
        result_q <= result_d;
        fifo_q   <= fifo_d;
    end

    assign o_busy          = cyc;
    assign o_valid         = valid_q;
    assign o_err           = err_q;
    assign o_wreg          = wreg_q;
    assign o_result        = result_q;
    assign wb.o_wb_cyc_gbl = cyc_gbl_q;
    assign wb.o_wb_cyc_lcl = cyc_lcl_q;
    assign wb.o_wb_stb_gbl = stb_gbl_q;
    assign wb.o_wb_stb_lcl = stb_lcl_q;
    assign wb.o_wb_we      = we_q;
    assign wb.o_wb_addr    = addr_q;
    assign wb.o_wb_data    = wdata_q;
    assign wb.o_wb_sel     = sel_q;
endmodule

// File: tb/tb_pipelined_memops.sv
// Bench for pipelined_memops: directed scenarios plus random traffic against a
// transaction-level model and a Wishbone slave with random stall/latency.
module tb_pipelined_memops;
    localparam int AW  = 30;
    localparam int LGD = 2;

    logic        gclk = 1'b0;
    logic        rst;
    logic        i_stb, i_lock;
    logic [2:0]  i_op;
    logic [31:0] i_addr, i_data;
    logic [4:0]  i_oreg;
    logic        o_busy, o_pipe_stalled, o_valid, o_err;
    logic [4:0]  o_wreg;
    logic [31:0] o_result;

    pipelined_memops_if #(.AW(AW)) wb ();

    pipelined_memops #(.ADDRESS_WIDTH(AW), .LGDEPTH(LGD), .IMPLEMENT_LOCK(0)) dut (
        .i_clk(gclk), .i_rst(rst), .i_stb(i_stb), .i_lock(i_lock), .i_op(i_op),
        .i_addr(i_addr), .i_data(i_data), .i_oreg(i_oreg), .o_busy(o_busy),
        .o_pipe_stalled(o_pipe_stalled), .o_valid(o_valid), .o_err(o_err),
        .o_wreg(o_wreg), .o_result(o_result), .wb(wb)
    );

    always #5 gclk = ~gclk;

    typedef struct { logic lcl; logic we; logic [AW-1:0] addr; logic [3:0] sel; logic [31:0] data; } bus_t;
    typedef struct { int kind; logic [4:0] wreg; logic [31:0] val; } resp_t; // 0 read, 1 misalign, 2 bus err
    typedef struct { int due; logic [31:0] data; } ack_t;

    bus_t  exp_bus [$];
    resp_t exp_resp [$];
    ack_t  ack_q [$];
    logic [31:0] mem [logic [29:0]];

    int nvec = 0, nbad = 0;
    int cyc_cnt = 0, last_ack_cyc = -10, n_ack = 0, err_at = 0;
    int lat = 1, stall_pct = 0, n_valid = 0, n_err = 0;
    bit stray = 0;
    logic [3:0]  last_sel;
    logic [31:0] last_data, last_res;
    logic        last_lcl, last_gbl;
    resp_t mr;
    bus_t  mb;
    ack_t  ma;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Reference model: what the bus and the result port should show for one accepted op
    task automatic model_accept(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [4:0] oreg);
        int n, off;
        bus_t b;
        resp_t r;
        logic [63:0] w;
        n   = (op[2:1] == 2'b10) ? 1 : (op[2:1] == 2'b01) ? 2 : 4;
        off = int'(addr[1:0]);
        if (off % n != 0) begin
            r = '{kind: 1, wreg: oreg, val: 32'h0};
            exp_resp.push_back(r);
            return;
        end
        b.lcl  = (addr[31:24] == 8'hff);
        b.we   = op[0];
        b.addr = addr[31:2];
        b.sel  = 4'h0;
        for (int k = off; k < off + n; k++) b.sel[3-k] = 1'b1;
        b.data = (n == 1) ? 32'(data[7:0]) * 32'h01010101 :
                 (n == 2) ? 32'(data[15:0]) * 32'h00010001 : data;
        exp_bus.push_back(b);
        if (!op[0]) begin
            w = 64'(rd_word(addr[31:2]));
            w = (w >> (8 * (4 - off - n))) & ((64'h1 << (8 * n)) - 1);
            r = '{kind: 0, wreg: oreg, val: w[31:0]};
            exp_resp.push_back(r);
        end
    endtask

    // Monitor results, then play the slave for this cycle
    always @(negedge gclk) begin
        cyc_cnt++;
        if (o_valid || o_err) begin
            chk("pulse_excl", 32'(o_valid & o_err), 0);
            chk("resp_pending", 32'(exp_resp.size() != 0), 1);
            if (exp_resp.size() != 0) begin
                mr = exp_resp.pop_front();
                chk("resp_kind", 32'(o_err), 32'(mr.kind != 0));
                if (mr.kind == 0) begin
                    chk("wreg", 32'(o_wreg), 32'(mr.wreg));
                    chk("result", o_result, mr.val);
                    chk("valid_lat", cyc_cnt, last_ack_cyc + 1);
                    last_res = o_result;
                end else if (mr.kind == 1) begin
                    chk("err_wreg", 32'(o_wreg), 32'(mr.wreg));
                end else begin
                    chk("err_cyc", 32'(wb.o_wb_cyc_gbl | wb.o_wb_cyc_lcl), 0);
                end
            end
            if (o_valid) n_valid++;
            if (o_err) n_err++;
        end
        wb.i_wb_ack  = 1'b0;
        wb.i_wb_err  = 1'b0;
        wb.i_wb_data = $urandom;
        if (stray) begin
            wb.i_wb_ack = 1'b1;
            stray = 0;
        end else if (ack_q.size() != 0 && ack_q[0].due <= cyc_cnt) begin
            ma = ack_q.pop_front();
            n_ack++;
            if (err_at != 0 && n_ack == err_at) begin
                wb.i_wb_err = 1'b1;
                ack_q.delete();
                exp_bus.delete();
                exp_resp.delete();
                exp_resp.push_back('{kind: 2, wreg: 5'd0, val: 32'h0});
                stray  = 1;
                err_at = 0;
            end else begin
                wb.i_wb_ack  = 1'b1;
                wb.i_wb_data = ma.data;
                last_ack_cyc = cyc_cnt;
            end
        end
        wb.i_wb_stall = ($urandom_range(99) < stall_pct);
        if ((wb.o_wb_stb_gbl || wb.o_wb_stb_lcl) && !wb.i_wb_stall) begin
            chk("bus_expected", 32'(exp_bus.size() != 0), 1);
            if (exp_bus.size() != 0) begin
                mb = exp_bus.pop_front();
                chk("bus_cyc_lcl", 32'(wb.o_wb_cyc_lcl), 32'(mb.lcl));
                chk("bus_cyc_gbl", 32'(wb.o_wb_cyc_gbl), 32'(!mb.lcl));
                chk("bus_stb_lcl", 32'(wb.o_wb_stb_lcl), 32'(mb.lcl));
                chk("bus_we", 32'(wb.o_wb_we), 32'(mb.we));
                chk("bus_addr", 32'(wb.o_wb_addr), 32'(mb.addr));
                chk("bus_sel", 32'(wb.o_wb_sel), 32'(mb.sel));
                if (mb.we) chk("bus_data", wb.o_wb_data, mb.data);
                ack_q.push_back('{due: cyc_cnt + lat, data: mb.we ? $urandom : rd_word(mb.addr)});
            end
            last_sel  = wb.o_wb_sel;
            last_data = wb.o_wb_data;
            last_lcl  = wb.o_wb_cyc_lcl;
            last_gbl  = wb.o_wb_cyc_gbl;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] oreg, output int stalls);
        bit done;
        done   = 0;
        stalls = 0;
        @(negedge gclk);
        i_stb = 1'b1; i_op = op; i_addr = addr; i_data = data; i_oreg = oreg;
        for (int t = 0; t < 300 && !done; t++) begin
            #1;
            if (!o_pipe_stalled) begin
                model_accept(op, addr, data, oreg);
                done = 1;
                @(posedge gclk);
            end else begin
                stalls++;
                @(negedge gclk);
            end
        end
        chk("accept", 32'(done), 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge gclk);
            i_stb = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        idle(1);
        while ((exp_resp.size() != 0 || exp_bus.size() != 0 || ack_q.size() != 0 || o_busy) && t < 500) begin
            @(negedge gclk);
            t++;
        end
        idle(2);
        chk({tag, "_resp_left"}, exp_resp.size(), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
    endtask

    initial begin
        int st [5];
        int v0, e0;
        logic [31:0] a;
        logic [2:0] op;
        rst = 1'b1; i_stb = 1'b0; i_lock = 1'b0; i_op = 3'b0;
        i_addr = 32'h0; i_data = 32'h0; i_oreg = 5'h0;
        idle(3);
        rst = 1'b0;
        idle(1);
        #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_stb", 32'(wb.o_wb_stb_gbl | wb.o_wb_stb_lcl), 0);
        chk("rst_stalled", 32'(o_pipe_stalled), 0);

        // byte read, big-endian lane 3
        mem[30'h400] = 32'hAABBCCDD;
        v0 = n_valid;
        issue(3'b100, 32'h00001003, 32'h0, 5'd7, st[0]);
        drain("r029");
        chk("r029_sel", 32'(last_sel), 32'h1);
        chk("r029_res", last_res, 32'h000000DD);
        chk("r029_nvalid", n_valid - v0, 1);

        // back-to-back word reads against a 4-deep pipe
        lat = 3;
        v0 = n_valid;
        for (int i = 0; i < 5; i++) issue(3'b000, 32'h100 + 32'(4 * i), 32'h0, 5'(10 + i), st[i]);
        for (int i = 0; i < 4; i++) chk("r030_nostall", st[i], 0);
        chk("r030_stall5", 32'(st[4] > 0), 1);
        drain("r030");
        chk("r030_nvalid", n_valid - v0, 5);

        // half write to local space
        lat = 1;
        v0 = n_valid;
        issue(3'b011, 32'hff000002, 32'h00001234, 5'd3, st[0]);
        drain("r031");
        chk("r031_lcl", 32'(last_lcl), 1);
        chk("r031_gbl", 32'(last_gbl), 0);
        chk("r031_sel", 32'(last_sel), 32'h3);
        chk("r031_data", last_data, 32'h12341234);
        chk("r031_novalid", n_valid - v0, 0);

        // bus error on the second of three reads
        lat = 5;
        v0 = n_valid; e0 = n_err;
        err_at = n_ack + 2;
        for (int i = 0; i < 3; i++) issue(3'b000, 32'h200 + 32'(4 * i), 32'h0, 5'(20 + i), st[i]);
        drain("r032");
        chk("r032_nvalid", n_valid - v0, 1);
        chk("r032_nerr", n_err - e0, 1);
        chk("r032_cnt", 32'(dut.npend_q), 0);

        // misaligned word read
        lat = 1;
        e0 = n_err;
        issue(3'b000, 32'h00000006, 32'h0, 5'd9, st[0]);
        drain("r033");
        chk("r033_nerr", n_err - e0, 1);

        // reset with two reads outstanding
        lat = 8;
        v0 = n_valid;
        issue(3'b000, 32'h300, 32'h0, 5'd1, st[0]);
        issue(3'b000, 32'h304, 32'h0, 5'd2, st[1]);
        idle(3);
        @(negedge gclk);
        #1;
        rst = 1'b1;
        exp_bus.delete(); exp_resp.delete(); ack_q.delete();
        @(negedge gclk);
        #1;
        chk("r034_busy", 32'(o_busy), 0);
        chk("r034_stb", 32'(wb.o_wb_stb_gbl | wb.o_wb_stb_lcl), 0);
        rst = 1'b0;
        lat = 2;
        issue(3'b000, 32'h308, 32'h0, 5'd4, st[0]);
        drain("r034");
        chk("r034_nvalid", n_valid - v0, 1);

        // random traffic with random stall and latency
        stall_pct = 25;
        for (int i = 0; i < 250; i++) begin
            op = 3'($urandom_range(7));
            a  = $urandom;
            if ($urandom_range(3) == 0) a[31:24] = 8'hff;
            if ($urandom_range(7) != 0) begin
                if (op[2:1] == 2'b01) a[0] = 1'b0;
                else if (op[2:1] != 2'b10) a[1:0] = 2'b00;
            end
            lat = $urandom_range(1, 4);
            issue(op, a, $urandom, 5'($urandom_range(31)), st[0]);
            if ($urandom_range(2) == 0) idle($urandom_range(1, 3));
        end
        drain("rand");
        stall_pct = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
